u_enc: RTL

- RV32I instruction encoder: the inverse of the core's instruction decoder.
- Accepts decoded fields (instruction class, register addresses, funct3/funct7, 32-bit immediate) over a valid/ready handshake.
- Produces the packed 32-bit instruction word plus a sequential instruction-memory write address.
- Used by the self-test program loader and by benches to generate stimulus; range/legality errors are flagged and replaced by NOP.

---
 rtl/u_pkg.sv | 41 ++++
 rtl/u_enc_fmt.sv | 97 +++++++++
 rtl/u_enc.sv | 109 ++++++++++
 3 files changed

// File: rtl/u_pkg.sv
// Shared definitions for the RV32I instruction encoder: class codes, opcodes
// and the immediate range helper used by the legality checker.
package u_pkg;

  typedef enum logic [3:0] {
    CLS_LUI   = 4'd0,
    CLS_AUIPC = 4'd1,
    CLS_JAL   = 4'd2,
    CLS_JALR  = 4'd3,
    CLS_B     = 4'd4,
    CLS_LD    = 4'd5,
    CLS_ST    = 4'd6,
    CLS_ALUI  = 4'd7,
    CLS_ALU   = 4'd8,
    CLS_F     = 4'd9,
    CLS_SYS   = 4'd10
  } cls_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_F     = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  // True when v is representable as an nbits-wide two's complement value,
  // i.e. every bit from nbits-1 upward equals the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] t;
    t = $unsigned($signed(v) >>> (nbits - 1));
    return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/u_enc_fmt.sv
// Combinational field packer and legality checker: decoded fields in, one
// RV32I word out. Illegal inputs produce NOP_INS with err set.
module u_enc_fmt
  import u_pkg::*;
(
  input  logic [3:0]  cls_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_shamt_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] ins_o,
  output logic        err_o
);

  logic [31:0] i_word;
  logic [31:0] raw;
  logic        bad;
  logic        imm_i_ok;
  logic        imm_b_ok;
  logic        imm_j_ok;
  logic        imm_u_ok;
  logic        is_shift;

  assign imm_i_ok = fits_signed(imm_i, 12);
  assign imm_b_ok = fits_signed(imm_i, 13) && !imm_i[0];
  assign imm_j_ok = fits_signed(imm_i, 21) && !imm_i[0];
  assign imm_u_ok = (imm_i[11:0] == 12'h000);
  assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

  // Opcode is patched in per class; the rest of the I-format is shared.
  assign i_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000000};

  always_comb begin
    raw = 32'h0000_0000;
    bad = 1'b0;
    case (cls_i)
      CLS_LUI: begin
        raw = {imm_i[31:12], rd_i, OP_LUI};
        bad = !imm_u_ok;
      end
      CLS_AUIPC: begin
        raw = {imm_i[31:12], rd_i, OP_AUIPC};
        bad = !imm_u_ok;
      end
      CLS_JAL: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        bad = !imm_j_ok;
      end
      CLS_JALR: begin
        raw = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
        bad = !imm_i_ok;
      end
      CLS_B: begin
        raw = {imm_i[12], imm_i[10:5], rs2_shamt_i, rs1_i, funct3_i,
               imm_i[4:1], imm_i[11], OP_B};
        bad = !imm_b_ok || (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      CLS_LD: begin
        raw = i_word | {25'd0, OP_LD};
        bad = !imm_i_ok;
      end
      CLS_ST: begin
        raw = {imm_i[11:5], rs2_shamt_i, rs1_i, funct3_i, imm_i[4:0], OP_ST};
        bad = !imm_i_ok;
      end
      CLS_ALUI: begin
        // Shift forms carry funct7/shamt in place of the immediate.
        if (is_shift) begin
          raw = {funct7_i, rs2_shamt_i, rs1_i, funct3_i, rd_i, OP_ALUI};
        end else begin
          raw = i_word | {25'd0, OP_ALUI};
          bad = !imm_i_ok;
        end
      end
      CLS_ALU: begin
        raw = {funct7_i, rs2_shamt_i, rs1_i, funct3_i, rd_i, OP_ALU};
      end
      CLS_F: begin
        raw = i_word | {25'd0, OP_F};
        bad = !imm_i_ok;
      end
      CLS_SYS: begin
        raw = i_word | {25'd0, OP_SYS};
        bad = !imm_i_ok;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  assign ins_o = bad ? NOP_INS : raw;
  assign err_o = bad;

endmodule

// File: rtl/u_enc.sv
// RV32I instruction encoder top: one-deep output register with valid/ready
// handshakes, sequential write-address counter and saturating error count.
module u_enc
  import u_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_ld,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cls,
  input  logic [4:0]        rd_a,
  input  logic [4:0]        rs1_a,
  input  logic [4:0]        rs2_a_shamt,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both 1. Once valid rises it stays high with stable data until the
  // transfer; ready may toggle freely and never depends on the same side's valid.

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_ins_q, out_ins_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] fmt_ins;
  logic        fmt_err;
  logic        in_fire;
  logic        out_fire;

  u_enc_fmt u_fmt (
    .cls_i       (in_cls),
    .rd_i        (rd_a),
    .rs1_i       (rs1_a),
    .rs2_shamt_i (rs2_a_shamt),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .imm_i       (imm),
    .ins_o       (fmt_ins),
    .err_o       (fmt_err)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_err_d   = out_err_q;
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_ins_d   = fmt_ins;
      out_err_d   = fmt_err;
      if (fmt_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // A base load wins over the post-transfer increment.
    if (base_ld) begin
      addr_d = base_addr & ~ADDR_W'(3);
    end else if (out_fire) begin
      addr_d = addr_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ins_q   <= 32'h0000_0000;
      out_err_q   <= 1'b0;
      addr_q      <= RST_ADDR;
      err_cnt_q   <= 8'h00;
    end else begin
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ins   = out_ins_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
